controle_varredura: RTL and testbench

CONTROLE_VARREDURA -- requirements
Module: controle_varredura

---
 rtl/controle_varredura.sv | 160 ++++++++++++++++
 tb/tb_controle_varredura.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_varredura.sv
// Sweep controller: steps the servo through four positions in ping-pong order and,
// at each position, waits for the servo to settle, then requests and supervises one distance measurement.
module controle_varredura #(
    parameter int TEMPO_POSICAO = 100000000,
    parameter int TEMPO_TIMEOUT = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       fim_medida,
    output logic [1:0] posicao,
    output logic       medir,
    output logic       pronto,
    output logic       timeout,
    output logic [2:0] db_estado
);

    localparam int TEMPO_MAX = (TEMPO_POSICAO > TEMPO_TIMEOUT) ? TEMPO_POSICAO : TEMPO_TIMEOUT;
    localparam int W_TIMER   = $clog2(TEMPO_MAX + 1);

    localparam logic [W_TIMER-1:0] FIM_ESPERA  = W_TIMER'(TEMPO_POSICAO - 1);
    localparam logic [W_TIMER-1:0] FIM_AGUARDA = W_TIMER'(TEMPO_TIMEOUT - 1);

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        PREPARA = 3'd1,
        ESPERA  = 3'd2,
        MEDE    = 3'd3,
        AGUARDA = 3'd4,
        PROXIMA = 3'd5
    } estado_t;

    estado_t              r_estado;
    estado_t              w_estado_prox;
    logic [W_TIMER-1:0]   r_timer;
    logic [W_TIMER-1:0]   w_timer_prox;
    logic [1:0]           r_posicao;
    logic [1:0]           w_posicao_prox;
    logic                 r_desce;
    logic                 w_desce_prox;
    logic                 w_medir;
    logic                 w_pronto;
    logic                 w_timeout;
    logic                 w_fim_espera;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado  <= INICIAL;
            r_timer   <= '0;
            r_posicao <= 2'b00;
            r_desce   <= 1'b0;
        end else begin
            r_estado  <= w_estado_prox;
            r_timer   <= w_timer_prox;
            r_posicao <= w_posicao_prox;
            r_desce   <= w_desce_prox;
        end
    end

    always_comb begin
        w_estado_prox  = r_estado;
        w_timer_prox   = r_timer;
        w_posicao_prox = r_posicao;
        w_desce_prox   = r_desce;
        w_medir        = 1'b0;
        w_pronto       = 1'b0;
        w_timeout      = 1'b0;
        w_fim_espera   = 1'b0;

        case (r_estado)
            INICIAL: begin
                if (ligar) begin
                    w_estado_prox = PREPARA;
                end
            end

            PREPARA: begin
                w_timer_prox   = '0;
                w_posicao_prox = 2'b00;
                w_desce_prox   = 1'b0;
                w_estado_prox  = ESPERA;
            end

            ESPERA: begin
                if (r_timer == FIM_ESPERA) begin
                    w_timer_prox  = '0;
                    w_estado_prox = MEDE;
                end else begin
                    w_timer_prox = r_timer + 1'b1;
                end
            end

            MEDE: begin
                w_medir       = 1'b1;
                w_timer_prox  = '0;
                w_estado_prox = AGUARDA;
            end

            AGUARDA: begin
                // A result arriving on the expiry cycle still counts as a normal completion.
                if (fim_medida) begin
                    w_pronto     = 1'b1;
                    w_fim_espera = 1'b1;
                end else if (r_timer == FIM_AGUARDA) begin
                    w_timeout    = 1'b1;
                    w_fim_espera = 1'b1;
                end else begin
                    w_timer_prox = r_timer + 1'b1;
                end
                if (w_fim_espera) begin
                    w_timer_prox  = '0;
                    w_estado_prox = ligar ? PROXIMA : INICIAL;
                end
            end

            PROXIMA: begin
                w_timer_prox  = '0;
                w_estado_prox = ESPERA;
                if (!r_desce) begin
                    if (r_posicao == 2'b11) begin
                        w_desce_prox   = 1'b1;
                        w_posicao_prox = 2'b10;
                    end else begin
                        w_posicao_prox = r_posicao + 2'b01;
                    end
                end else begin
                    if (r_posicao == 2'b00) begin
                        w_desce_prox   = 1'b0;
                        w_posicao_prox = 2'b01;
                    end else begin
                        w_posicao_prox = r_posicao - 2'b01;
                    end
                end
            end

            default: begin
                w_estado_prox = INICIAL;
            end
        endcase

        // Dropping ligar aborts at once, except that an outstanding measurement is allowed to finish.
        if (!ligar && (r_estado != AGUARDA)) begin
            w_estado_prox = INICIAL;
            w_medir       = 1'b0;
        end

        if (w_estado_prox == INICIAL) begin
            w_timer_prox   = '0;
            w_posicao_prox = 2'b00;
            w_desce_prox   = 1'b0;
        end
    end

    assign posicao   = r_posicao;
    assign medir     = w_medir;
    assign pronto    = w_pronto;
    assign timeout   = w_timeout;
    assign db_estado = r_estado;

endmodule

// File: tb/tb_controle_varredura.sv
// Bench for controle_varredura: an event-list model of the sweep feeds a scoreboard;
// a negedge monitor checks every pulse and every scheduled state/position probe.
module tb_controle_varredura;

    localparam int TP = 10;
    localparam int TT = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic       fim_medida;
    logic [1:0] posicao;
    logic       medir;
    logic       pronto;
    logic       timeout;
    logic [2:0] db_estado;

    controle_varredura #(
        .TEMPO_POSICAO(TP),
        .TEMPO_TIMEOUT(TT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ligar      (ligar),
        .fim_medida (fim_medida),
        .posicao    (posicao),
        .medir      (medir),
        .pronto     (pronto),
        .timeout    (timeout),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Pulse record: {kind(1=medir,2=pronto,3=timeout), posicao, cycle}
    logic [23:0] exp_q[$];

    typedef struct {
        int         c;
        logic [7:0] v;      // {db_estado, posicao, medir, pronto, timeout}
        bit         vazio;  // also require the pulse queue to be drained
    } probe_t;
    probe_t probe_q[$];

    int fim_q[$];
    int dly_q[$];

    function automatic logic [23:0] rec(input logic [1:0] k, input logic [1:0] p, input int c);
        return {k, p, c[19:0]};
    endfunction

    // Ping-pong sweep as a triangle wave of period 6.
    function automatic logic [1:0] pos_at(input int i);
        int k;
        k = i % 6;
        return (k <= 3) ? 2'(k) : 2'(6 - k);
    endfunction

    task automatic probe(input int c, input logic [7:0] v, input bit vazio);
        probe_t p;
        p.c     = c;
        p.v     = v;
        p.vazio = vazio;
        probe_q.push_back(p);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [23:0] m_act;
    logic [23:0] m_exp;
    logic [7:0]  m_est;
    probe_t      m_p;

    always @(negedge clock) begin
        if (medir || pronto || timeout) begin
            total++;
            if ($countones({medir, pronto, timeout}) != 1) begin
                bad++;
                $display("FAIL pulse_onehot cyc=%0d got=%b want=one-hot", cyc, {medir, pronto, timeout});
            end
            m_act = {medir ? 2'd1 : (pronto ? 2'd2 : 2'd3), posicao, 20'(cyc)};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse got kind/pos/cyc=%0d/%0d/%0d want=none",
                         m_act[23:22], m_act[21:20], m_act[19:0]);
            end else begin
                m_exp = exp_q.pop_front();
                if (m_act !== m_exp) begin
                    bad++;
                    $display("FAIL pulse got kind/pos/cyc=%0d/%0d/%0d want=%0d/%0d/%0d",
                             m_act[23:22], m_act[21:20], m_act[19:0],
                             m_exp[23:22], m_exp[21:20], m_exp[19:0]);
                end
            end
        end
        while (probe_q.size() > 0 && probe_q[0].c <= cyc) begin
            m_p   = probe_q.pop_front();
            m_est = {db_estado, posicao, medir, pronto, timeout};
            total++;
            if (m_p.c != cyc || m_est !== m_p.v) begin
                bad++;
                $display("FAIL probe cyc=%0d at=%0d got est/pos/pulses=%0d/%0d/%b want=%0d/%0d/%b",
                         m_p.c, cyc, m_est[7:5], m_est[4:3], m_est[2:0],
                         m_p.v[7:5], m_p.v[4:3], m_p.v[2:0]);
            end
            if (m_p.vazio) begin
                total++;
                if (exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL missing_pulses cyc=%0d got pending=%0d want=0", cyc, exp_q.size());
                end
            end
        end
    end

    // modo 0: ligar drops desloc cycles after the last completion (1..TP+2, 0 = random).
    // modo 1: ligar drops desloc cycles after the last medir, inside AGUARDA (0 = random).
    task automatic run_sweep(input int n, input int modo, input int desloc);
        int c0, m, e, d, drop_c, end_c;
        c0 = cyc;
        ligar = 1'b1;
        fim_medida = 1'b0;
        probe(c0 + 1, {3'd1, 2'b00, 3'b000}, 1'b0);
        probe(c0 + 2, {3'd2, 2'b00, 3'b000}, 1'b0);
        m = c0 + TP + 2;
        e = m;
        for (int i = 0; i < n; i++) begin
            d = dly_q[i];
            if (i > 0) m = e + TP + 2;
            exp_q.push_back(rec(2'd1, pos_at(i), m));
            if (d >= 1 && d <= TT) begin
                e = m + d;
                exp_q.push_back(rec(2'd2, pos_at(i), e));
            end else begin
                e = m + TT;
                exp_q.push_back(rec(2'd3, pos_at(i), e));
            end
            if (d >= 1) fim_q.push_back(m + d);
        end
        if (modo == 0) begin
            if (desloc == 0) desloc = $urandom_range(1, TP + 2);
            drop_c = e + desloc;
            probe(drop_c + 1, 8'h00, 1'b0);
        end else begin
            if (desloc == 0) desloc = $urandom_range(1, e - m);
            drop_c = m + desloc;
            probe(e + 1, 8'h00, 1'b0);
        end
        end_c = drop_c + TT + 10;
        probe(end_c, 8'h00, 1'b1);
        while (cyc < end_c + 1) begin
            step();
            ligar = (cyc < drop_c);
            if (fim_q.size() > 0 && fim_q[0] == cyc) begin
                fim_medida = 1'b1;
                void'(fim_q.pop_front());
            end else begin
                fim_medida = 1'b0;
            end
        end
        fim_q.delete();
        dly_q.delete();
        ligar = 1'b0;
        fim_medida = 1'b0;
    endtask

    // Reset lands mid-ESPERA of the second position, between clock edges.
    task automatic run_reset();
        int c0, m, e, r;
        c0 = cyc;
        ligar = 1'b1;
        fim_medida = 1'b0;
        probe(c0 + 1, {3'd1, 2'b00, 3'b000}, 1'b0);
        m = c0 + TP + 2;
        e = m + 3;
        exp_q.push_back(rec(2'd1, 2'b00, m));
        exp_q.push_back(rec(2'd2, 2'b00, e));
        fim_q.push_back(e);
        fim_q.push_back(e + 4);
        r = e + 7;
        probe(r - 1, {3'd2, 2'b01, 3'b000}, 1'b0);
        probe(r, 8'h00, 1'b1);
        while (cyc < r) begin
            step();
            if (fim_q.size() > 0 && fim_q[0] == cyc) begin
                fim_medida = 1'b1;
                void'(fim_q.pop_front());
            end else begin
                fim_medida = 1'b0;
            end
        end
        #1;
        reset = 1'b1;
        ligar = 1'b0;
        fim_medida = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        probe(r + 25, 8'h00, 1'b1);
        while (cyc < r + 26) step();
        fim_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        ligar = 1'b0;
        fim_medida = 1'b0;
        probe(2, 8'h00, 1'b0);
        repeat (3) step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++) dly_q.push_back(3);
        run_sweep(8, 0, TP + 2);

        dly_q.push_back(0);
        dly_q.push_back(3);
        run_sweep(2, 0, 1);

        run_reset();

        dly_q.push_back(3);
        run_sweep(1, 1, 1);

        dly_q.push_back(TT);
        dly_q.push_back(1);
        dly_q.push_back(0);
        run_sweep(3, 1, 0);

        for (int k = 0; k < 4; k++) begin
            int n;
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) dly_q.push_back($urandom_range(0, TT + 4));
            run_sweep(n, $urandom_range(0, 1), 0);
        end

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
